// File: rtl/div_iter_responder.sv
// rtl/div_iter_responder.sv - multicycle radix-2 restoring divider, responder end of the divisor/dividend/dout streams
module div_iter_responder #(
   parameter int WIDTH  = 32,
   parameter int SIGNED = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
   input  logic               s_axis_divisor_tvalid,
   output logic               s_axis_divisor_tready,
   input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
   input  logic               s_axis_dividend_tvalid,
   output logic               s_axis_dividend_tready,
   output logic [2*WIDTH-1:0] m_axis_dout_tdata,
   output logic               m_axis_dout_tvalid
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic             dvd_cap, dvs_cap;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] dvd_raw, dvd_mag, dvs_mag;
   logic             dvd_neg, dvs_neg;
   logic [WIDTH-1:0] rem, quo;

   // Magnitude uses an unsigned WIDTH-bit view, so the most negative value maps onto itself.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
      if (SIGNED != 0 && v[WIDTH-1])
         return -v;
      else
         return v;
   endfunction

   function automatic logic is_neg(input logic [WIDTH-1:0] v);
      return (SIGNED != 0) && v[WIDTH-1];
   endfunction

   logic dvd_fire, dvs_fire, dvd_have, dvs_have;
   assign dvd_fire = s_axis_dividend_tvalid && s_axis_dividend_tready;
   assign dvs_fire = s_axis_divisor_tvalid && s_axis_divisor_tready;
   assign dvd_have = dvd_cap || dvd_fire;
   assign dvs_have = dvs_cap || dvs_fire;

   // The first step seeds from the captured dividend instead of a separate load cycle.
   logic [WIDTH-1:0] src_rem, src_quo;
   logic [WIDTH:0]   shifted, trial, quo_shift;
   assign src_rem   = (count == '0) ? '0 : rem;
   assign src_quo   = (count == '0) ? dvd_mag : quo;
   assign shifted   = {src_rem, src_quo[WIDTH-1]};
   assign trial     = shifted - {1'b0, dvs_mag};
   assign quo_shift = {src_quo, ~trial[WIDTH]};

   logic             sign_q, sign_r;
   logic [WIDTH-1:0] q_fix, r_fix;
   assign sign_q = dvd_neg ^ dvs_neg;
   assign sign_r = dvd_neg;
   assign q_fix  = sign_q ? -quo : quo;
   assign r_fix  = sign_r ? -rem : rem;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state                  <= IDLE;
         dvd_cap                <= 1'b0;
         dvs_cap                <= 1'b0;
         count                  <= '0;
         dvd_raw                <= '0;
         dvd_mag                <= '0;
         dvs_mag                <= '0;
         dvd_neg                <= 1'b0;
         dvs_neg                <= 1'b0;
         rem                    <= '0;
         quo                    <= '0;
         s_axis_dividend_tready <= 1'b1;
         s_axis_divisor_tready  <= 1'b1;
         m_axis_dout_tdata      <= '0;
         m_axis_dout_tvalid     <= 1'b0;
      end else begin
         m_axis_dout_tvalid <= 1'b0;
         case (state)
            IDLE: begin
               if (dvd_fire) begin
                  dvd_raw <= s_axis_dividend_tdata;
                  dvd_mag <= magnitude(s_axis_dividend_tdata);
                  dvd_neg <= is_neg(s_axis_dividend_tdata);
               end
               if (dvs_fire) begin
                  dvs_mag <= magnitude(s_axis_divisor_tdata);
                  dvs_neg <= is_neg(s_axis_divisor_tdata);
               end
               dvd_cap                <= dvd_have;
               dvs_cap                <= dvs_have;
               s_axis_dividend_tready <= !dvd_have;
               s_axis_divisor_tready  <= !dvs_have;
               if (dvd_have && dvs_have) begin
                  state <= BUSY;
                  count <= '0;
               end
            end
            BUSY: begin
               rem   <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
               quo   <= quo_shift[WIDTH-1:0];
               count <= count + 1'b1;
               if (count == CW'(WIDTH - 1))
                  state <= DONE;
            end
            DONE: begin
               // A zero divisor bypasses sign fix-up and returns the raw dividend as remainder.
               if (dvs_mag == '0)
                  m_axis_dout_tdata <= {{WIDTH{1'b1}}, dvd_raw};
               else
                  m_axis_dout_tdata <= {q_fix, r_fix};
               m_axis_dout_tvalid <= 1'b1;
               dvd_cap            <= 1'b0;
               dvs_cap            <= 1'b0;
               state              <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_iter_responder.sv
// tb/tb_div_iter_responder.sv - scoreboard bench for div_iter_responder, unsigned (index 0) and signed (index 1) instances
module tb_div_iter_responder;

   typedef struct {
      logic [63:0] data;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] dvd_d [2];
   logic        dvd_v [2];
   logic        dvd_r [2];
   logic [31:0] dvs_d [2];
   logic        dvs_v [2];
   logic        dvs_r [2];
   logic [63:0] dout_d [2];
   logic        dout_v [2];

   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t q0[$];
   exp_t q1[$];
   bit   post [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   div_iter_responder #(.WIDTH(32), .SIGNED(0)) u_divu (
      .clk(clk), .reset(reset),
      .s_axis_divisor_tdata(dvs_d[0]), .s_axis_divisor_tvalid(dvs_v[0]), .s_axis_divisor_tready(dvs_r[0]),
      .s_axis_dividend_tdata(dvd_d[0]), .s_axis_dividend_tvalid(dvd_v[0]), .s_axis_dividend_tready(dvd_r[0]),
      .m_axis_dout_tdata(dout_d[0]), .m_axis_dout_tvalid(dout_v[0])
   );

   div_iter_responder #(.WIDTH(32), .SIGNED(1)) u_div (
      .clk(clk), .reset(reset),
      .s_axis_divisor_tdata(dvs_d[1]), .s_axis_divisor_tvalid(dvs_v[1]), .s_axis_divisor_tready(dvs_r[1]),
      .s_axis_dividend_tdata(dvd_d[1]), .s_axis_dividend_tvalid(dvd_v[1]), .s_axis_dividend_tready(dvd_r[1]),
      .m_axis_dout_tdata(dout_d[1]), .m_axis_dout_tvalid(dout_v[1])
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain arithmetic; signed math in 64 bits so MIN/-1 needs no special case.
   function automatic logic [63:0] model(input int s, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return {32'hFFFF_FFFF, a};
      if (s == 0) return {a / b, a % b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {q[31:0], r[31:0]};
   endfunction

   task automatic issue(input int m, input logic [31:0] a, input logic [31:0] b,
                        input int da, input int db, input bit push, output int e0);
      bit   ga, gb, pa, pb;
      int   ea, eb;
      exp_t x;
      ga = 0; gb = 0; pa = 0; pb = 0; ea = 0; eb = 0;
      for (int t = 0; t < 400 && !(ga && gb); t++) begin
         @(negedge clk);
         if (pa) begin
            chk("dividend_ready_drop", dvd_r[m], 1'b0);
            if (!gb) chk("divisor_ready_held", dvs_r[m], 1'b1);
            pa = 0;
         end
         if (pb) begin
            chk("divisor_ready_drop", dvs_r[m], 1'b0);
            if (!ga) chk("dividend_ready_held", dvd_r[m], 1'b1);
            pb = 0;
         end
         dvd_d[m] = a;
         dvs_d[m] = b;
         dvd_v[m] = (t >= da) && !ga;
         dvs_v[m] = (t >= db) && !gb;
         if (dvd_v[m] && dvd_r[m]) begin ga = 1; pa = 1; ea = cyc + 1; end
         if (dvs_v[m] && dvs_r[m]) begin gb = 1; pb = 1; eb = cyc + 1; end
      end
      @(negedge clk);
      dvd_v[m] = 1'b0;
      dvs_v[m] = 1'b0;
      chk("handshake_done", {ga, gb}, 2'b11);
      if (pa) chk("dividend_ready_drop", dvd_r[m], 1'b0);
      if (pb) chk("divisor_ready_drop", dvs_r[m], 1'b0);
      e0 = (ea > eb) ? ea : eb;
      if (push) begin
         x.data = model(m, a, b);
         x.cyc  = e0 + 33;
         if (m == 0) q0.push_back(x); else q1.push_back(x);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && (q0.size() + q1.size()) != 0; i++) @(negedge clk);
      chk("queue_drained", q0.size() + q1.size(), 0);
      @(negedge clk);
   endtask

   task automatic mon(input int m);
      exp_t x;
      if (post[m]) begin
         chk("ready_after_strobe", {dvd_r[m], dvs_r[m]}, 2'b11);
         post[m] = 0;
      end
      if (dout_v[m]) begin
         post[m] = 1;
         if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
            chk("unexpected_strobe", dout_v[m], 1'b0);
         end else begin
            if (m == 0) x = q0.pop_front(); else x = q1.pop_front();
            chk(m == 0 ? "divu_tdata" : "div_tdata", dout_d[m], x.data);
            chk(m == 0 ? "divu_strobe_cycle" : "div_strobe_cycle", cyc, x.cyc);
         end
      end
   endtask

   initial begin
      post[0] = 0;
      post[1] = 0;
      forever begin
         @(negedge clk);
         mon(0);
         mon(1);
      end
   end

   initial begin
      int e, e1, e2, m, dl_a, dl_b;
      logic [31:0] a, b;
      for (int i = 0; i < 2; i++) begin
         dvd_d[i] = '0; dvd_v[i] = 1'b0; dvs_d[i] = '0; dvs_v[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("reset_ready", {dvd_r[i], dvs_r[i]}, 2'b11);
         chk("reset_tvalid", dout_v[i], 1'b0);
         chk("reset_tdata", dout_d[i], 64'd0);
      end

      issue(0, 32'd100, 32'd7, 0, 0, 1, e);
      issue(1, -32'sd7, 32'd2, 0, 0, 1, e);
      issue(1, 32'd7, -32'sd2, 0, 0, 1, e);
      issue(1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1, e);
      drain();
      issue(0, 32'd50, 32'd5, 0, 3, 1, e);
      issue(1, 32'hFFFF_FF00, 32'd0, 1, 0, 1, e);
      issue(0, 32'd123, 32'd0, 0, 0, 1, e);
      issue(1, 32'd5, 32'd9, 2, 0, 1, e);
      drain();

      // Abort a division mid-iteration; the queue holds nothing, so any strobe is flagged.
      issue(0, 32'd1000, 32'd7, 0, 0, 0, e);
      repeat (10) @(posedge clk);
      #2 reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("post_abort_ready", {dvd_r[0], dvs_r[0]}, 2'b11);
      chk("post_abort_tvalid", dout_v[0], 1'b0);
      issue(0, 32'd9, 32'd3, 0, 0, 1, e);
      drain();

      issue(0, 32'd1000, 32'd3, 0, 0, 1, e1);
      issue(0, 32'd77, 32'd5, 0, 0, 1, e2);
      chk("back_to_back_gap_ok", (e2 - e1) >= 35, 1'b1);
      drain();

      for (int i = 0; i < 40; i++) begin
         m = $urandom_range(0, 1);
         a = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: b = $urandom_range(1, 15);
            3: begin a = 32'h8000_0000; b = $urandom; end
            4: b = a + $urandom_range(1, 100);
            default: b = $urandom;
         endcase
         dl_a = $urandom_range(0, 3);
         dl_b = $urandom_range(0, 3);
         issue(m, a, b, dl_a, dl_b, 1, e);
      end
      drain();
      repeat (40) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/div_iter_responder.md
Name: div_iter_responder

Overview:
- Multicycle 32-bit integer divider: the responder end of the divisor/dividend/dout stream handshake that the execute stage drives for DIV/DIVU.
- Two independent operand channels with valid/ready handshakes, and one result channel that carries a single-cycle valid pulse and has no back-pressure.
- One quotient bit is produced per cycle using radix-2 restoring division on operand magnitudes, followed by sign fix-up.
- Instantiated once with SIGNED=1 (div) and once with SIGNED=0 (divu).

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH bits and iteration count = WIDTH.
- SIGNED, 1, 1 = two's-complement operands (DIV semantics), 0 = unsigned (DIVU).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- s_axis_divisor_tdata  input  WIDTH  divisor.
- s_axis_divisor_tvalid  input  1  divisor valid.
- s_axis_divisor_tready  output  1  divider can accept the divisor.
- s_axis_dividend_tdata  input  WIDTH  dividend.
- s_axis_dividend_tvalid  input  1  dividend valid.
- s_axis_dividend_tready  output  1  divider can accept the dividend.
- m_axis_dout_tdata  output  2*WIDTH  {quotient[2W-1:W], remainder[W-1:0]}.
- m_axis_dout_tvalid  output  1  one-cycle result strobe.

Behaviour:
- Reset (async, active-high, any time including mid-operation):
  - state=IDLE; both captured flags cleared; iteration counter=0.
  - Both tready=1, m_axis_dout_tvalid=0, m_axis_dout_tdata=0.
  - Any in-flight division is discarded and produces no strobe.
- States:
  - IDLE: collects operands.
  - BUSY: WIDTH iterations.
  - DONE: one cycle, result strobe.
- IDLE:
  - Each channel's tready = 1 while that channel's operand is not yet captured.
  - A channel is captured on a rising edge with tvalid&&tready; its tready then drops to 0 on the next cycle.
  - Channels are independent: they may be captured in the same edge or in either order, any number of cycles apart.
  - When both are held after an edge E0, go to BUSY; E0 is the later capture edge.
- Capture stores:
  - the magnitude of each operand (abs value if SIGNED, else raw);
  - sign_q = sign(dividend) XOR sign(divisor);
  - sign_r = sign(dividend);
  - the raw dividend (for the divide-by-zero case).
- BUSY:
  - Edges E0+1..E0+WIDTH each perform one restoring step: shift {partial remainder, dividend magnitude} left 1; trial-subtract the divisor magnitude using a WIDTH+1 bit subtractor; if non-negative, keep the difference and set the quotient LSB to 1, else restore and set 0.
  - Counter runs 0..WIDTH-1; at WIDTH-1 go to DONE.
  - Both tready=0 in BUSY and DONE; operand valids are ignored.
- DONE:
  - At edge E0+WIDTH+1, load m_axis_dout_tdata and set m_axis_dout_tvalid=1.
  - tvalid is high for exactly one cycle and drops at E0+WIDTH+2.
  - tdata holds its value until the next result.
  - Return to IDLE with both flags cleared; both tready=1 in the cycle after the strobe.
  - Latency from the later operand handshake edge to the strobe: WIDTH+1 cycles (33 for WIDTH=32).
- Sign fix-up (SIGNED=1):
  - quotient = sign_q ? -q : q, truncated toward zero.
  - remainder = sign_r ? -r : r; the remainder takes the dividend's sign.
  - Magnitude of 0x80000000 is 0x80000000, using a WIDTH-bit unsigned view.
- Boundary cases:
  - Overflow 0x80000000 / -1: quotient=0x80000000, remainder=0. No trap, latency unchanged.
  - Divisor zero (both modes): quotient=all ones, remainder=raw dividend. Fixed latency, no hang, no sign fix-up.
  - Dividend < divisor (unsigned magnitudes): quotient=0, remainder=dividend.
- The result channel has no tready. The consumer must sample it in the strobe cycle.

Test Plan:
- Unsigned (SIGNED=0): dividend=100 and divisor=7 presented in the same cycle → both tready drop next cycle; tvalid high exactly at E0+33 for 1 cycle; tdata=0x0000000E_00000002; both tready=1 the following cycle.
- Signed: -7 / 2 → tdata=0xFFFFFFFD_FFFFFFFF. Signed 7 / -2 → 0xFFFFFFFD_00000001. Signed 0x80000000 / 0xFFFFFFFF → 0x80000000_00000000.
- Skewed handshake: dividend=50 valid at cycle 0, divisor=5 valid at cycle 3 → dividend tready=0 from cycle 1 while divisor tready stays 1; strobe 33 cycles after the divisor edge; tdata=0x0000000A_00000000.
- Divide by zero: signed 0xFFFFFF00 / 0 and unsigned 123 / 0 → quotient 0xFFFFFFFF with remainder 0xFFFFFF00 and 123 respectively; strobe at E0+33.
- Reset asserted asynchronously at E0+10 mid-BUSY, released 2 cycles later → no tvalid strobe, both tready=1; a following 9 / 3 returns 0x00000003_00000000 with normal latency.
- Back-to-back: a second operand pair is offered continuously during BUSY → not accepted until the cycle after the first strobe; both results are correct and strobes are ≥34 cycles apart.
